// File: rtl/ram_dumper.sv
// Streams every RAM byte, address 0 upward, to the host over the UART and waits
// for the host to echo each byte back before moving on; failures retransmit, then abort.
module ram_dumper #(
    parameter int ADDR_BITS   = 16,
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_rd_en,
    input  logic [7:0]           ram_q,
    output logic [7:0]           tx_data,
    output logic                 transmit,
    input  logic                 tx_done,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    output logic                 dumping,
    output logic                 done,
    output logic                 error
);

    localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0]   TIMER_LAST  = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]           RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST   = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_NEXT,
        S_FINISH,
        S_ABORT
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [3:0]           retry_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            ram_addr  <= '0;
            ram_rd_en <= 1'b0;
            tx_data   <= '0;
            transmit  <= 1'b0;
            dumping   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle and are raised only on the
            // transition into S_READ / S_SEND, so each lasts exactly one cycle.
            ram_rd_en <= 1'b0;
            transmit  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        ram_addr  <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        dumping   <= 1'b1;
                        retry_cnt <= '0;
                        ram_rd_en <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_READ: state <= S_LATCH;
                S_LATCH: begin
                    tx_data  <= ram_q;
                    transmit <= 1'b1;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    timer <= '0;
                    state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (tx_done) state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    timer <= timer + 1'b1;
                    // A received byte on the timeout cycle takes priority over the timeout.
                    if (rx_done && (rx_data == tx_data)) begin
                        state <= S_NEXT;
                    end else if (rx_done || (timer == TIMER_LAST)) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            transmit  <= 1'b1;
                            state     <= S_SEND;
                        end else begin
                            state <= S_ABORT;
                        end
                    end
                end
                S_NEXT: begin
                    retry_cnt <= '0;
                    if (ram_addr == ADDR_LAST) begin
                        state <= S_FINISH;
                    end else begin
                        ram_addr  <= ram_addr + 1'b1;
                        ram_rd_en <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    dumping <= 1'b0;
                    state   <= S_IDLE;
                end
                S_ABORT: begin
                    error   <= 1'b1;
                    dumping <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dumper.sv
// Bench for ram_dumper: RAM, UART and echoing host models; a queue model of the
// expected reads and transmits is compared against the DUT on every strobe.
module tb_ram_dumper;

    localparam int ADDR_BITS   = 4;
    localparam int MAX_RETRY   = 2;
    localparam int ACK_TIMEOUT = 100;
    localparam int N           = 1 << ADDR_BITS;

    logic                 clk     = 1'b0;
    logic                 rst_n   = 1'b0;
    logic                 trigger = 1'b0;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_rd_en;
    logic [7:0]           ram_q   = '0;
    logic [7:0]           tx_data;
    logic                 transmit;
    logic                 tx_done = 1'b0;
    logic [7:0]           rx_data = '0;
    logic                 rx_done = 1'b0;
    logic                 dumping;
    logic                 done;
    logic                 error;

    ram_dumper #(
        .ADDR_BITS  (ADDR_BITS),
        .MAX_RETRY  (MAX_RETRY),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trigger  (trigger),
        .ram_addr (ram_addr),
        .ram_rd_en(ram_rd_en),
        .ram_q    (ram_q),
        .tx_data  (tx_data),
        .transmit (transmit),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .dumping  (dumping),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [N];
    always @(posedge clk) if (ram_rd_en) ram_q <= ram[ram_addr];

    int n_checks = 0;
    int n_errors = 0;

    int  fail_left   [32];
    bit  fail_silent [32];
    int  reply_delay [32];
    bit  stray_en    [32];
    int  host_idx;
    bit  gap_armed;
    bit  silent_seen;
    int  last_done_cyc;
    int  tx_count;

    logic [7:0] exp_q[$];
    int         exp_rd_q[$];
    bit         exp_abort;
    int         exp_end_addr;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard: every read strobe and every transmit pulse must match the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rd_en) begin
                if (exp_rd_q.size() == 0) check("unexpected_read", 1, 0);
                else                      check("read_addr", int'(ram_addr), exp_rd_q.pop_front());
            end
            if (transmit) begin
                tx_count++;
                if (exp_q.size() == 0) check("unexpected_tx", 1, 0);
                else                   check("tx_data", int'(tx_data), int'(exp_q.pop_front()));
            end
        end
    end

    // UART with a fixed send time, plus the host that echoes (or misbehaves).
    initial begin : link
        logic [7:0] sent;
        int         done_cyc;
        done_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_n && transmit) begin
                sent = tx_data;
                if (gap_armed) begin
                    check("resend_gap", cyc - last_done_cyc, ACK_TIMEOUT + 1);
                    gap_armed = 1'b0;
                end
                for (int k = 1; k <= 9; k++) begin
                    @(posedge clk); #1;
                    rx_done = (k == 4) && stray_en[host_idx];
                    if (k == 4) rx_data = ~sent;
                    tx_done = (k == 9);
                    if (k == 9) done_cyc = cyc;
                end
                @(posedge clk); #1;
                tx_done = 1'b0;
                if (fail_left[host_idx] > 0) begin
                    fail_left[host_idx]--;
                    if (fail_silent[host_idx]) begin
                        gap_armed     = 1'b1;
                        last_done_cyc = done_cyc;
                        silent_seen   = 1'b1;
                    end else begin
                        repeat (2) begin @(posedge clk); #1; end
                        rx_data = 8'h00;
                        rx_done = 1'b1;
                        @(posedge clk); #1;
                        rx_done = 1'b0;
                    end
                end else begin
                    repeat (reply_delay[host_idx] - 1) begin @(posedge clk); #1; end
                    rx_data = sent;
                    rx_done = 1'b1;
                    @(posedge clk); #1;
                    rx_done = 1'b0;
                    host_idx++;
                end
            end
        end
    end

    task automatic setup();
        for (int i = 0; i < 32; i++) begin
            fail_left[i]   = 0;
            fail_silent[i] = 1'b0;
            reply_delay[i] = 3;
            stray_en[i]    = 1'b0;
        end
        host_idx    = 0;
        gap_armed   = 1'b0;
        silent_seen = 1'b0;
        tx_count    = 0;
        exp_q.delete();
        exp_rd_q.delete();
    endtask

    // Each address is read once; its byte goes out once per failure plus the final
    // attempt, and more failures than retries ends the dump at that address.
    task automatic build_model();
        exp_abort    = 1'b0;
        exp_end_addr = N - 1;
        for (int a = 0; a < N; a++) begin
            exp_rd_q.push_back(a);
            if (fail_left[a] > MAX_RETRY) begin
                repeat (MAX_RETRY + 1) exp_q.push_back(ram[a]);
                exp_abort    = 1'b1;
                exp_end_addr = a;
                break;
            end
            repeat (fail_left[a] + 1) exp_q.push_back(ram[a]);
        end
    endtask

    task automatic pulse_trigger();
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0;
    endtask

    task automatic run_and_check(input string name);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done || error) break;
        end
        repeat (2) @(negedge clk);
        check({name, "_done"},    int'(done),     exp_abort ? 0 : 1);
        check({name, "_error"},   int'(error),    exp_abort ? 1 : 0);
        check({name, "_dumping"}, int'(dumping),  0);
        check({name, "_addr"},    int'(ram_addr), exp_end_addr);
        check({name, "_tx_left"}, exp_q.size(),   0);
        check({name, "_rd_left"}, exp_rd_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) ram[i] = 8'(i) ^ 8'hA5;
        setup();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr",     int'(ram_addr),  0);
        check("rst_rd_en",    int'(ram_rd_en), 0);
        check("rst_tx_data",  int'(tx_data),   0);
        check("rst_transmit", int'(transmit),  0);
        check("rst_dumping",  int'(dumping),   0);
        check("rst_done",     int'(done),      0);
        check("rst_error",    int'(error),     0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: clean dump of A5, A4, ... AA
        setup();
        build_model();
        check("s1_model_first", int'(exp_q[0]),  8'hA5);
        check("s1_model_last",  int'(exp_q[15]), 8'hAA);
        check("s1_model_len",   exp_q.size(),    16);
        pulse_trigger();
        run_and_check("s1");
        check("s1_tx_count", tx_count, 16);

        // 2: one bad echo at addr 3 -> A6 sent twice
        setup();
        fail_left[3] = 1;
        build_model();
        check("s2_model_len", exp_q.size(), 17);
        pulse_trigger();
        check("s2_dumping_started", int'(dumping), 1);
        check("s2_done_cleared",    int'(done),    0);
        run_and_check("s2");
        check("s2_tx_count", tx_count, 17);

        // 3: silent host at addr 5 -> three sends of A0, then abort at addr 5
        setup();
        fail_left[5]   = 99;
        fail_silent[5] = 1'b1;
        build_model();
        check("s3_model_len", exp_q.size(), 8);
        check("s3_model_byte", int'(exp_q[7]), 8'hA0);
        pulse_trigger();
        run_and_check("s3");
        check("s3_tx_count", tx_count, 8);

        // 4: extra triggers and stray rx_done during S_WAIT_TX
        setup();
        stray_en[2] = 1'b1;
        stray_en[9] = 1'b1;
        build_model();
        pulse_trigger();
        repeat (30) @(posedge clk);
        pulse_trigger();
        repeat (150) @(posedge clk);
        pulse_trigger();
        run_and_check("s4");

        // 5: reset while waiting for the echo of addr 7, then a fresh dump
        setup();
        fail_left[7]   = 99;
        fail_silent[7] = 1'b1;
        build_model();
        pulse_trigger();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (silent_seen) break;
        end
        check("s5_reached_addr7", int'(silent_seen), 1);
        repeat (20) @(posedge clk);
        #1;
        check("s5_dumping_before_reset", int'(dumping), 1);
        rst_n = 1'b0;
        #1;
        check("s5_rst_addr",     int'(ram_addr),  0);
        check("s5_rst_rd_en",    int'(ram_rd_en), 0);
        check("s5_rst_tx_data",  int'(tx_data),   0);
        check("s5_rst_transmit", int'(transmit),  0);
        check("s5_rst_dumping",  int'(dumping),   0);
        check("s5_rst_done",     int'(done),      0);
        check("s5_rst_error",    int'(error),     0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        setup();
        build_model();
        pulse_trigger();
        run_and_check("s5");

        // 6: two bad echoes at addr 10, then the good echo lands on the timeout cycle
        setup();
        fail_left[10]   = 2;
        reply_delay[10] = ACK_TIMEOUT;
        build_model();
        check("s6_model_len", exp_q.size(), 18);
        pulse_trigger();
        run_and_check("s6");
        check("s6_tx_count", tx_count, 18);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
